instruction_queue: RTL and testbench

Byte-granular prefetch queue directly upstream of decode stage 1. It accepts 4-byte code fetches from the bus unit and buffers them in a circular byte store. It presents a 16-byte, oldest-first window to the decoder and retires a variable number of bytes per cycle as the decoder reports instruction or prefix consumption. A flush empties the queue for control transfers and supports an unaligned restart target.

---
 rtl/instruction_queue_pkg.sv | 9 +
 rtl/instruction_queue_window.sv | 33 +++
 rtl/instruction_queue.sv | 126 ++++++++++++
 tb/tb_instruction_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_queue_pkg.sv
// Shared types and constants for the decode-stage byte prefetch queue.
package instruction_queue_pkg;

  localparam int IQ_WINDOW_BYTES = 16;
  localparam int IQ_FETCH_BYTES  = 4;

  typedef logic [7:0] code_byte_t;

endpackage

// File: rtl/instruction_queue_window.sv
// Combinational rotate/mask of the circular byte store into the oldest-first
// 16-byte decode window plus its valid byte count.
module instruction_queue_window
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH_BYTES = 32,
  localparam int PTR_W = $clog2(DEPTH_BYTES)
) (
  input  code_byte_t       store_i       [DEPTH_BYTES],
  input  logic [PTR_W-1:0] rd_ptr_i,
  input  logic [PTR_W:0]   count_i,
  output code_byte_t       window_o      [IQ_WINDOW_BYTES],
  output logic [4:0]       valid_bytes_o
);

  localparam logic [PTR_W:0] WIN_CNT = IQ_WINDOW_BYTES[PTR_W:0];

  always_comb begin
    valid_bytes_o = 5'd16;
    if (count_i < WIN_CNT) begin
      valid_bytes_o = 5'(count_i);
    end
  end

  // Pointer arithmetic wraps modulo the store depth, so a window straddling
  // the top of the store comes out contiguous.
  for (genvar gi = 0; gi < IQ_WINDOW_BYTES; gi++) begin : g_win
    logic [PTR_W-1:0] idx;
    assign idx          = rd_ptr_i + PTR_W'(gi);
    assign window_o[gi] = (5'(gi) < valid_bytes_o) ? store_i[idx] : 8'h00;
  end

endmodule

// File: rtl/instruction_queue.sv
// Byte-granular instruction prefetch queue feeding decode stage 1.
// Optional INSTRUCTION_QUEUE_STALL_COUNTER_EN adds a saturating starved-cycle counter.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH_BYTES = 32,
  parameter int FETCH_BYTES = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_fetch_valid,
  output logic       o_fetch_ready,
  input  code_byte_t i_fetch_data [FETCH_BYTES],
  input  logic       i_flush,
  input  logic [1:0] i_flush_offset,
  output code_byte_t o_instruction [IQ_WINDOW_BYTES],
  output logic [4:0] o_valid_bytes,
  input  logic       i_consume_valid,
  input  logic [4:0] i_consume_bytes,
  output logic       o_error_overconsume,
  output logic [15:0] o_stall_count
);

  localparam int PTR_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_BYTES);
  localparam logic [CNT_W-1:0] FETCH_CNT = CNT_W'(FETCH_BYTES);

  code_byte_t       store_q [DEPTH_BYTES];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       skip_q, skip_d;
  logic             err_q, err_d;

  logic             push, pop, illegal;
  logic [CNT_W-1:0] push_len, pop_len;

  // Ready looks only at current occupancy; a same-cycle pop earns no credit.
  assign o_fetch_ready = (DEPTH_CNT - count_q) >= FETCH_CNT;
  assign push_len      = FETCH_CNT - CNT_W'(skip_q);
  assign pop_len       = CNT_W'(i_consume_bytes);

  assign push    = i_fetch_valid && o_fetch_ready && !i_flush;
  assign pop     = i_consume_valid && (i_consume_bytes != 5'd0)
                   && (i_consume_bytes <= o_valid_bytes) && !i_flush;
  assign illegal = i_consume_valid && !pop && !i_flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    skip_d   = skip_q;
    err_d    = 1'b0;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      skip_d   = i_flush_offset;
    end else begin
      err_d   = illegal;
      count_d = count_q + (push ? push_len : '0) - (pop ? pop_len : '0);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(i_consume_bytes);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + push_len[PTR_W-1:0];
        skip_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      skip_q   <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      skip_q   <= skip_d;
      err_q    <= err_d;
    end
  end

  // Store contents need no reset: bytes outside [rd_ptr, rd_ptr+count) are masked.
  always_ff @(posedge i_clock) begin
    for (int j = 0; j < FETCH_BYTES; j++) begin
      if (push && (j >= int'(skip_q))) begin
        store_q[wr_ptr_q + PTR_W'(j) - PTR_W'(skip_q)] <= i_fetch_data[j];
      end
    end
  end

  assign o_error_overconsume = err_q;

`ifdef INSTRUCTION_QUEUE_STALL_COUNTER_EN
  logic [15:0] stall_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      stall_q <= 16'h0000;
    end else if (!i_flush && (o_valid_bytes < 5'd16) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_count = stall_q;
`else
  assign o_stall_count = 16'h0000;
`endif

  instruction_queue_window #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_window (
    .store_i      (store_q),
    .rd_ptr_i     (rd_ptr_q),
    .count_i      (count_q),
    .window_o     (o_instruction),
    .valid_bytes_o(o_valid_bytes)
  );

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: directed scenarios then random traffic,
// checked against a byte-queue reference model.
module tb_instruction_queue;
  import instruction_queue_pkg::*;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_valid;
  logic       fetch_ready;
  code_byte_t fetch_data [IQ_FETCH_BYTES];
  logic       flush;
  logic [1:0] flush_offset;
  code_byte_t instr [IQ_WINDOW_BYTES];
  logic [4:0] valid_bytes;
  logic       consume_valid;
  logic [4:0] consume_bytes;
  logic       err;
  logic [15:0] stall;

  always #5 clk = ~clk;

  instruction_queue #(.DEPTH_BYTES(DEPTH), .FETCH_BYTES(4)) dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_fetch_valid      (fetch_valid),
    .o_fetch_ready      (fetch_ready),
    .i_fetch_data       (fetch_data),
    .i_flush            (flush),
    .i_flush_offset     (flush_offset),
    .o_instruction      (instr),
    .o_valid_bytes      (valid_bytes),
    .i_consume_valid    (consume_valid),
    .i_consume_bytes    (consume_bytes),
    .o_error_overconsume(err),
    .o_stall_count      (stall)
  );

  typedef struct {
    logic [4:0]   vb;
    logic [127:0] win;
    logic         rdy;
    logic         err;
    logic [15:0]  stall;
  } exp_t;

  exp_t        exp_q[$];
  byte unsigned mq[$];
  int          mskip = 0;
  int          mstall = 0;
  int          checks = 0;
  int          failures = 0;
  int          txn = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [127:0] dut_window();
    logic [127:0] w;
    for (int k = 0; k < IQ_WINDOW_BYTES; k++) w[8*k+:8] = instr[k];
    return w;
  endfunction

  function automatic void model_reset();
    mq.delete();
    mskip  = 0;
    mstall = 0;
  endfunction

  // Called at a falling edge: drive one cycle of stimulus, predict the state
  // visible after the next rising edge, then advance to the next falling edge.
  task automatic step(input bit fv, input logic [31:0] d, input bit fl,
                      input logic [1:0] off, input bit cv, input logic [4:0] cb);
    int   cnt, vb;
    bit   rdy, ok;
    exp_t e;
    fetch_valid   = fv;
    for (int j = 0; j < 4; j++) fetch_data[j] = d[8*j+:8];
    flush         = fl;
    flush_offset  = off;
    consume_valid = cv;
    consume_bytes = cb;

    cnt = mq.size();
    vb  = (cnt > 16) ? 16 : cnt;
    rdy = (DEPTH - cnt) >= 4;
`ifdef INSTRUCTION_QUEUE_STALL_COUNTER_EN
    if (vb < 16 && !fl && mstall < 65535) mstall++;
`endif
    e.err = 1'b0;
    if (fl) begin
      mq.delete();
      mskip = int'(off);
    end else begin
      ok    = cv && (cb != 0) && (int'(cb) <= vb);
      e.err = cv && !ok;
      if (ok) repeat (int'(cb)) void'(mq.pop_front());
      if (fv && rdy) begin
        for (int j = mskip; j < 4; j++) mq.push_back(d[8*j+:8]);
        mskip = 0;
      end
    end
    cnt   = mq.size();
    e.vb  = 5'((cnt > 16) ? 16 : cnt);
    e.rdy = (DEPTH - cnt) >= 4;
    e.win = '0;
    for (int k = 0; k < int'(e.vb); k++) e.win[8*k+:8] = mq[k];
    e.stall = 16'(mstall);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_valid"}, 128'(valid_bytes), 128'd0);
    chk({tag, "_ready"}, 128'(fetch_ready), 128'd1);
    chk({tag, "_err"},   128'(err),         128'd0);
    chk({tag, "_stall"}, 128'(stall),       128'd0);
    chk({tag, "_win"},   dut_window(),      128'd0);
  endtask

  // Monitor: compares every cycle for which the driver queued an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("valid_bytes", 128'(valid_bytes), 128'(e.vb));
        chk("window",      dut_window(),      e.win);
        chk("fetch_ready", 128'(fetch_ready), 128'(e.rdy));
        chk("overconsume", 128'(err),         128'(e.err));
        chk("stall_count", 128'(stall),       128'(e.stall));
        $display("txn %0d vb=%0d rdy=%0b err=%0b stall=%0d w0=%02h",
                 txn, valid_bytes, fetch_ready, err, stall, instr[0]);
      end
    end
  end

  initial begin
    int waited;
    logic [31:0] beat;
    rst = 1'b1;
    fetch_valid = 1'b0; flush = 1'b0; flush_offset = 2'd0;
    consume_valid = 1'b0; consume_bytes = 5'd0;
    for (int j = 0; j < 4; j++) fetch_data[j] = 8'h00;
    @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Fill with 0x00.. in 4-byte beats until full, then hold a beat while full.
    for (int b = 0; b < 8; b++) begin
      beat = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
      step(1'b1, beat, 1'b0, 2'd0, 1'b0, 5'd0);
    end
    step(1'b1, 32'hEEEEEEEE, 1'b0, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 5'd4);
    step(1'b1, 32'h23222120, 1'b0, 2'd0, 1'b1, 5'd3);
    idle();

    // Unaligned restart, then push during flush.
    step(1'b0, 32'h0, 1'b1, 2'd3, 1'b0, 5'd0);
    step(1'b1, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b0, 5'd0);
    step(1'b1, 32'hB3B2B1B0, 1'b0, 2'd0, 1'b0, 5'd0);
    step(1'b1, 32'hC3C2C1C0, 1'b1, 2'd0, 1'b1, 5'd2);
    idle();

    // Illegal consumes with 5 bytes queued.
    step(1'b0, 32'h0, 1'b1, 2'd3, 1'b0, 5'd0);
    step(1'b1, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b0, 5'd0);
    step(1'b1, 32'hB3B2B1B0, 1'b0, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 5'd6);
    idle();
    step(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 5'd0);
    idle();
    step(1'b0, 32'h0, 1'b1, 2'd0, 1'b1, 5'd20);

    // Walk rd_ptr up to 30 so the window straddles the store boundary.
    for (int b = 0; b < 7; b++) step(1'b1, $urandom, 1'b0, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 5'd16);
    step(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 5'd12);
    step(1'b1, 32'h13121110, 1'b0, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 5'd2);
    step(1'b1, 32'h17161514, 1'b0, 2'd0, 1'b0, 5'd0);
    step(1'b1, 32'h1B1A1918, 1'b0, 2'd0, 1'b0, 5'd0);
    idle();

    // Asynchronous reset mid-cycle with a pending skip; next beat lands whole.
    step(1'b0, 32'h0, 1'b1, 2'd2, 1'b0, 5'd0);
    fetch_valid = 1'b0; flush = 1'b0; consume_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 32'h44332211, 1'b0, 2'd0, 1'b0, 5'd0);
    idle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit          fv, fl, cv;
      logic [4:0]  cb;
      fv = ($urandom % 10) < 7;
      fl = ($urandom % 40) == 0;
      cv = ($urandom % 10) < 5;
      cb = (($urandom % 6) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 8));
      step(fv, $urandom, fl, 2'($urandom), cv, cb);
    end
    idle();

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("drain", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
